uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 9 +
 rtl/data_sampling.sv | 23 ++
 rtl/uart_rx.sv | 89 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: FSM states, parity constants and parity helper shared by the UART Tx and Rx
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam logic EVEN = 1'b1;
   localparam logic ODD  = 1'b0;
   function automatic logic parity_bit(input logic [7:0] d, input logic ptype);
      return (ptype == EVEN) ? ^d : ~^d;
   endfunction
endpackage

// File: rtl/data_sampling.sv
// data_sampling: 3-point majority vote of the serial line around the bit centre
module data_sampling (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic       i_rx,
   input  logic [5:0] i_prescale,
   input  logic [5:0] i_edge_cnt,
   output logic       o_bit
);
   logic [5:0] w_mid;
   logic [2:0] r_samp;
   assign w_mid = i_prescale >> 1;
   assign o_bit = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst)
         r_samp <= '1;
      else if (i_en) begin
         if (i_edge_cnt == w_mid - 6'd1) r_samp[0] <= i_rx;
         if (i_edge_cnt == w_mid)        r_samp[1] <= i_rx;
         if (i_edge_cnt == w_mid + 6'd1) r_samp[2] <= i_rx;
      end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity and registered result pulses
module uart_rx
   import uart_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic [5:0] Prescale,
   input  logic       PAR_EN,
   input  logic       parity_type,
   output logic [7:0] P_DATA,
   output logic       Data_Valid,
   output logic       par_err,
   output logic       stp_err
);
   state_t     r_state;
   logic [5:0] r_edge_cnt, r_prescale;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_par_en, r_ptype, r_par_fail;
   logic       w_bit, w_busy, w_wrap;
   assign w_busy = (r_state != IDLE);
   assign w_wrap = w_busy && (r_edge_cnt >= r_prescale - 6'd1);
   data_sampling u_sampler (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_en       (w_busy),
      .i_rx       (RX_IN),
      .i_prescale (r_prescale),
      .i_edge_cnt (r_edge_cnt),
      .o_bit      (w_bit)
   );
   // The detection cycle is edge 0 of the start bit, so the counter leaves IDLE at 1.
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         r_state    <= IDLE;
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
         r_prescale <= 6'd8;
         r_par_en   <= 1'b0;
         r_ptype    <= EVEN;
         r_par_fail <= 1'b0;
         r_shift    <= '0;
         P_DATA     <= '0;
         Data_Valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         if (!w_busy) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            if (!RX_IN) begin
               r_state    <= START;
               r_edge_cnt <= 6'd1;
               r_prescale <= Prescale;
               r_par_en   <= PAR_EN;
               r_ptype    <= parity_type;
               r_par_fail <= 1'b0;
            end
         end else begin
            r_edge_cnt <= w_wrap ? 6'd0 : r_edge_cnt + 6'd1;
            if (w_wrap) begin
               r_bit_cnt <= r_bit_cnt + 4'd1;
               case (r_state)
                  START:  r_state <= w_bit ? IDLE : DATA;
                  DATA: begin
                     r_shift <= {w_bit, r_shift[7:1]};
                     if (r_bit_cnt == 4'd8) r_state <= r_par_en ? PARITY : STOP;
                  end
                  PARITY: begin
                     r_par_fail <= (w_bit != parity_bit(r_shift, r_ptype));
                     r_state    <= STOP;
                  end
                  STOP: begin
                     r_state    <= IDLE;
                     P_DATA     <= r_shift;
                     Data_Valid <= !r_par_fail && w_bit;
                     par_err    <= r_par_fail;
                     stp_err    <= !w_bit;
                  end
                  default: r_state <= IDLE;
               endcase
            end
         end
      end
endmodule
